lap_time_buffer: RTL and testbench
==================================

# lap_time_buffer

Parametrised lap-time capture buffer for the stopwatch datapath. On each lap pulse it snapshots the running time code into a DEPTH-entry circular store, which the display/readout logic drains in order. It generalises the single-bit enable/set/reset flip-flop into a WIDTH×DEPTH register array with:
- an asynchronous reset;
- a synchronous clear;
- a global enable;
- occupancy tracking, overflow detection and a held "last lap" register.

## Interface
Parameters:
- WIDTH, 24, bit width of the time code captured per lap
- DEPTH, 8, number of storage entries; power of two, ≥2
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- clear  input  1  synchronous flush; same effect as reset, applied at next rising edge
- en  input  1  global enable; when 0, no capture and no read occur
- lap  input  1  capture request, sampled each cycle
- time_in  input  WIDTH  current stopwatch time code
- rd_req  input  1  read request, sampled each cycle
- rd_data  output  WIDTH  oldest entry, registered; held between reads
- rd_valid  output  1  one-cycle pulse; rd_data is new this cycle
- last_lap  output  WIDTH  time_in value at the most recent enabled lap
- count  output  CW  number of stored entries, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  sticky; set when a lap is dropped

## Operation
- Priority order: reset (async) > clear > en > lap/rd_req.
- **Reset values (reset asserted, or clear at an edge):**
  - rd_data=0, rd_valid=0, last_lap=0, count=0, overflow=0;
  - write and read pointers = 0;
  - storage contents don't-care.
- **en=0:** all state held; rd_valid=0 on the next edge.
- **Write** (wr = en & lap & (!full | rd)):
  - store time_in at wr_ptr;
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1→0.
- **Read** (rd = en & rd_req & !empty):
  - rd_data ← entry[rd_ptr];
  - rd_ptr increments modulo DEPTH;
  - rd_valid ← 1.
  - Otherwise rd_valid ← 0 and rd_data is held.
- **Count:** +1 on write only, −1 on read only, unchanged when both or neither occur.
- **Full and lap, same-cycle read:** the write is accepted, because the read frees the slot.
- **Full and lap, no read:** the lap is dropped; overflow ← 1 and stays set until reset or clear.
- **Empty and both lap and rd_req:** the write is accepted; the read is ignored (no bypass), so rd_valid=0.
- **Empty and rd_req only:** ignored; rd_valid=0; nothing else changes.
- **last_lap:** ← time_in on every cycle with en & lap, including dropped laps, so the display always shows the newest lap.
- **Flags:** empty and full are derived combinationally from the registered count.

## Timing
- **Capture:** the edge that samples lap writes the entry. count, full and empty update at that same edge.
- **Read latency:** 1 cycle. rd_req is sampled at edge N; rd_data and rd_valid are valid after edge N, for one cycle.
- **Back-to-back reads:** rd_req held high drains one entry per cycle. rd_valid stays high for exactly min(requests, count) cycles.
- **Reset:** async assertion forces all outputs to reset values without a clock edge. Deassertion is synchronous to clk externally.
- **clear mid-stream:** an in-flight rd_valid is cleared at the same edge. Concurrent lap and rd_req are ignored.
- **FIFO order:** entries are read strictly in write order, across any number of pointer wraps.

## Test plan
- **Reset/clear:** reset pulse mid-cycle, then lap with en=1 and time_in=0x000123.
  - After reset, before any clock: all outputs zero, with no clock edge needed.
  - After the lap edge: count=1, last_lap=0x000123.
  - clear on the next edge: count=0, overflow=0, last_lap=0.
- **Fill and overflow:** DEPTH=8; lap on 9 consecutive cycles, time_in=1..9.
  - full=1 after the 8th lap.
  - The 9th lap leaves count=8, sets overflow=1 and sets last_lap=9.
  - Draining returns 1..8 in order; overflow stays 1.
- **Full with simultaneous lap and read:** with the buffer full (1..8), lap time_in=0xA and rd_req in the same cycle.
  - rd_data=1 and rd_valid=1; count stays 8; overflow stays 0.
  - Subsequent drain returns 2..8, then 0xA.
- **Empty edge cases:**
  - rd_req when empty: rd_valid=0, count=0.
  - lap time_in=0x55 with rd_req on empty: count=1, rd_valid=0.
  - Next rd_req: rd_data=0x55.
- **Enable gating:** en=0 with lap and rd_req asserted for 5 cycles. count, last_lap and rd_data are unchanged; rd_valid=0.
- **Wrap-around:** 20 writes interleaved with reads, keeping count between 1 and 3. All 20 values are read back in order with no loss, confirming wrap of both pointers.

Source files
------------

// File: rtl/lap_time_buffer_if.sv
// rtl/lap_time_buffer_if.sv - capture/readout bus of the lap-time buffer
//
// Purpose: groups the lap capture request, readout handshake and status
//          outputs of lap_time_buffer into one bundle.
// Signals:
//   lap       capture request (master -> buffer)
//   time_in   running time code to capture (master -> buffer)
//   rd_req    read request (master -> buffer)
//   rd_data   oldest entry, registered (buffer -> master)
//   rd_valid  one-cycle pulse, rd_data is new (buffer -> master)
//   last_lap  time code of the most recent enabled lap (buffer -> master)
//   count     stored entries, 0..DEPTH (buffer -> master)
//   empty     count == 0 (buffer -> master)
//   full      count == DEPTH (buffer -> master)
//   overflow  sticky, a lap was dropped (buffer -> master)
interface lap_time_buffer_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             lap;
  logic [WIDTH-1:0] time_in;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [WIDTH-1:0] last_lap;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;

  modport master (
    output lap, time_in, rd_req,
    input  rd_data, rd_valid, last_lap, count, empty, full, overflow
  );

  modport slave (
    input  lap, time_in, rd_req,
    output rd_data, rd_valid, last_lap, count, empty, full, overflow
  );
endinterface

// File: rtl/lap_time_buffer.sv
// rtl/lap_time_buffer.sv - lap-time capture buffer (circular FIFO of time codes)
//
// Purpose: on each enabled lap pulse, stores time_in into a DEPTH-entry
//          circular store that the readout logic drains in write order.
//          Tracks occupancy, flags dropped laps and holds the newest lap.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state immediately
//   clear  synchronous flush, same effect as reset at the next edge
//   en     global enable; when low nothing is captured or read
//   bus    lap_time_buffer_if.slave (lap/time_in/rd_req in, status out)
module lap_time_buffer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  lap_time_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] last_lap_q;
  logic             overflow_q;

  logic empty_w;
  logic full_w;
  logic rd;
  logic wr;
  logic drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A read on a full buffer frees a slot in the same cycle, so the
  // concurrent lap is accepted rather than dropped.
  assign rd   = en & bus.rd_req & ~empty_w;
  assign wr   = en & bus.lap & (~full_w | rd);
  assign drop = en & bus.lap & full_w & ~rd;

  // Storage is not reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr && !clear && !reset) begin
      mem[wr_ptr] <= bus.time_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      last_lap_q <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      last_lap_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd) begin
        rd_ptr    <= rd_ptr + PW'(1);
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd;

      if (wr && !rd) begin
        count_q <= count_q + CW'(1);
      end else if (rd && !wr) begin
        count_q <= count_q - CW'(1);
      end

      // Dropped laps still update the display value.
      if (en && bus.lap) begin
        last_lap_q <= bus.time_in;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.last_lap = last_lap_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_lap_time_buffer.sv
// tb/tb_lap_time_buffer.sv - directed self-checking bench for lap_time_buffer
module tb_lap_time_buffer;
  localparam int WIDTH = 24;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  logic clear;
  logic en;

  int checks;
  int errors;

  lap_time_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lap_time_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (en),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    clear       = 1'b0;
    en          = 1'b0;
    bus.lap     = 1'b0;
    bus.time_in = '0;
    bus.rd_req  = 1'b0;

    // Async reset mid-cycle, checked before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_last_lap", 32'(bus.last_lap), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full", 32'(bus.full), 32'h0);
    tick();
    reset = 1'b0;

    // Single lap then clear
    en = 1'b1;
    bus.lap = 1'b1;
    bus.time_in = 24'h000123;
    tick();
    bus.lap = 1'b0;
    check("lap1_count", 32'(bus.count), 32'h1);
    check("lap1_last_lap", 32'(bus.last_lap), 32'h123);
    check("lap1_empty", 32'(bus.empty), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", 32'(bus.count), 32'h0);
    check("clr_overflow", 32'(bus.overflow), 32'h0);
    check("clr_last_lap", 32'(bus.last_lap), 32'h0);

    // Fill 1..9, 9th dropped
    for (int i = 1; i <= 9; i++) begin
      bus.lap = 1'b1;
      bus.time_in = 24'(i);
      tick();
      if (i == 8) begin
        check("fill8_full", 32'(bus.full), 32'h1);
        check("fill8_overflow", 32'(bus.overflow), 32'h0);
      end
    end
    bus.lap = 1'b0;
    check("ovf_count", 32'(bus.count), 32'h8);
    check("ovf_overflow", 32'(bus.overflow), 32'h1);
    check("ovf_last_lap", 32'(bus.last_lap), 32'h9);

    bus.rd_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain1_valid", 32'(bus.rd_valid), 32'h1);
      check("drain1_data", 32'(bus.rd_data), 32'(i));
    end
    tick();
    bus.rd_req = 1'b0;
    check("drain1_end_valid", 32'(bus.rd_valid), 32'h0);
    check("drain1_end_hold", 32'(bus.rd_data), 32'h8);
    check("drain1_end_empty", 32'(bus.empty), 32'h1);
    check("drain1_end_ovf", 32'(bus.overflow), 32'h1);

    // Full with simultaneous lap and read
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.lap = 1'b1;
      bus.time_in = 24'(i);
      tick();
    end
    bus.time_in = 24'h00000A;
    bus.rd_req = 1'b1;
    tick();
    bus.lap = 1'b0;
    check("fullrw_data", 32'(bus.rd_data), 32'h1);
    check("fullrw_valid", 32'(bus.rd_valid), 32'h1);
    check("fullrw_count", 32'(bus.count), 32'h8);
    check("fullrw_overflow", 32'(bus.overflow), 32'h0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      check("drain2_valid", 32'(bus.rd_valid), 32'h1);
      check("drain2_data", 32'(bus.rd_data), (i == 9) ? 32'hA : 32'(i));
    end
    tick();
    check("drain2_end_valid", 32'(bus.rd_valid), 32'h0);
    check("drain2_end_count", 32'(bus.count), 32'h0);

    // Empty edge cases (rd_req still high)
    tick();
    check("emp_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("emp_rd_count", 32'(bus.count), 32'h0);
    bus.lap = 1'b1;
    bus.time_in = 24'h000055;
    tick();
    bus.lap = 1'b0;
    check("emp_lr_count", 32'(bus.count), 32'h1);
    check("emp_lr_valid", 32'(bus.rd_valid), 32'h0);
    tick();
    bus.rd_req = 1'b0;
    check("emp_next_data", 32'(bus.rd_data), 32'h55);
    check("emp_next_valid", 32'(bus.rd_valid), 32'h1);
    check("emp_next_count", 32'(bus.count), 32'h0);

    // Enable gating
    bus.lap = 1'b1;
    bus.time_in = 24'h000077;
    tick();
    en = 1'b0;
    bus.rd_req = 1'b1;
    bus.time_in = 24'h000099;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0_count", 32'(bus.count), 32'h1);
      check("en0_last_lap", 32'(bus.last_lap), 32'h77);
      check("en0_rd_data", 32'(bus.rd_data), 32'h55);
      check("en0_rd_valid", 32'(bus.rd_valid), 32'h0);
    end
    en = 1'b1;
    bus.lap = 1'b0;
    tick();
    bus.rd_req = 1'b0;
    check("en1_rd_data", 32'(bus.rd_data), 32'h77);
    check("en1_rd_valid", 32'(bus.rd_valid), 32'h1);

    // Wrap-around: 20 writes, reads lag by one cycle
    for (int j = 0; j < 20; j++) begin
      bus.lap = 1'b1;
      bus.time_in = 24'(32'h100 + j);
      bus.rd_req = (j > 0);
      tick();
      check("wrap_count", 32'(bus.count), 32'h1);
      if (j > 0) begin
        check("wrap_data", 32'(bus.rd_data), 32'h100 + 32'(j - 1));
        check("wrap_valid", 32'(bus.rd_valid), 32'h1);
      end
    end
    bus.lap = 1'b0;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("wrap_last_data", 32'(bus.rd_data), 32'h113);
    check("wrap_last_count", 32'(bus.count), 32'h0);
    check("wrap_overflow", 32'(bus.overflow), 32'h0);

    // Async reset while data present
    bus.lap = 1'b1;
    bus.time_in = 24'h000042;
    tick();
    bus.lap = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst2_count", 32'(bus.count), 32'h0);
    check("rst2_last_lap", 32'(bus.last_lap), 32'h0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
